// File: rtl/alu_seq_n_if.sv
// Operand/result bundle for alu_seq_n: request side (start, operands, opcode)
// and result side (registered result, status flags, busy/done handshake).
interface alu_seq_n_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   CNT;
  logic [N-1:0] D;
  logic         carry_out;
  logic         zero;
  logic         negative;
  logic         overflow;
  logic         busy;
  logic         done;

  modport master (
    output start, A, B, CNT,
    input  D, carry_out, zero, negative, overflow, busy, done
  );

  modport slave (
    input  start, A, B, CNT,
    output D, carry_out, zero, negative, overflow, busy, done
  );
endinterface

// File: rtl/alu_seq_n.sv
// Registered N-bit ALU. Add/sub/compare/logic complete at the accept edge;
// rotates and shifts step one bit position per clock through an internal
// accumulator, so no barrel shifter is built.
module alu_seq_n #(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_seq_n_if.slave  bus
);
  localparam int S = $clog2(N);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t       state_reg;
  logic [N-1:0] acc_reg;
  logic [3:0]   op_reg;
  logic [S-1:0] remain_reg;
  logic [N-1:0] d_reg;
  logic         carry_reg;
  logic         zero_reg;
  logic         negative_reg;
  logic         overflow_reg;
  logic         busy_reg;
  logic         done_reg;

  logic [S-1:0] k;
  logic         is_shift;
  logic [N-1:0] b_eff;
  logic [N:0]   sum;
  logic [N-1:0] res;
  logic         res_c;
  logic         res_v;
  logic [N-1:0] step_acc;
  logic         step_bit;

  assign k        = bus.B[S-1:0];
  assign is_shift = (bus.CNT >= 4'h9) && (bus.CNT <= 4'hD);

  // Single-cycle result for everything except a shift with a non-zero amount.
  // Subtraction reuses the adder as A + ~B + 1.
  always_comb begin
    b_eff = (bus.CNT == 4'h1) ? ~bus.B : bus.B;
    sum   = {1'b0, bus.A} + {1'b0, b_eff} + {{N{1'b0}}, (bus.CNT == 4'h1)};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (bus.CNT)
      4'h0, 4'h1: begin
        res   = sum[N-1:0];
        res_c = sum[N];
        res_v = (bus.A[N-1] == b_eff[N-1]) && (sum[N-1] != bus.A[N-1]);
      end
      4'h2: res = {N{bus.A >= bus.B}};
      4'h3: res = {N{bus.A <  bus.B}};
      4'h4: res = {N{bus.A != bus.B}};
      4'h5: res = {N{bus.A == bus.B}};
      4'h6: res = bus.A & bus.B;
      4'h7: res = bus.A | bus.B;
      4'h8: res = bus.A ^ bus.B;
      4'h9, 4'hA, 4'hB, 4'hC, 4'hD: res = bus.A;  // shift by zero
      default: res = '0;
    endcase
  end

  // One-position step of the captured shift/rotate and the bit it pushes out.
  always_comb begin
    step_acc = acc_reg;
    step_bit = 1'b0;
    case (op_reg)
      4'h9: begin step_acc = {acc_reg[N-2:0], acc_reg[N-1]}; step_bit = acc_reg[N-1]; end
      4'hA: begin step_acc = {acc_reg[0], acc_reg[N-1:1]};   step_bit = acc_reg[0];   end
      4'hB: begin step_acc = {acc_reg[N-2:0], 1'b0};         step_bit = acc_reg[N-1]; end
      4'hC: begin step_acc = {1'b0, acc_reg[N-1:1]};         step_bit = acc_reg[0];   end
      4'hD: begin step_acc = {acc_reg[N-1], acc_reg[N-1:1]}; step_bit = acc_reg[0];   end
      default: begin step_acc = acc_reg; step_bit = 1'b0; end
    endcase
  end

  // Control FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      op_reg       <= '0;
      remain_reg   <= '0;
      d_reg        <= '0;
      carry_reg    <= 1'b0;
      zero_reg     <= 1'b0;
      negative_reg <= 1'b0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (is_shift && (k != '0)) begin
              acc_reg    <= bus.A;
              op_reg     <= bus.CNT;
              remain_reg <= k;
              busy_reg   <= 1'b1;
              state_reg  <= SHIFT;
            end else begin
              d_reg        <= res;
              carry_reg    <= res_c;
              overflow_reg <= res_v;
              zero_reg     <= (res == '0);
              negative_reg <= res[N-1];
              done_reg     <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc_reg    <= step_acc;
          remain_reg <= remain_reg - S'(1);
          if (remain_reg == S'(1)) begin
            d_reg        <= step_acc;
            carry_reg    <= step_bit;
            overflow_reg <= 1'b0;
            zero_reg     <= (step_acc == '0);
            negative_reg <= step_acc[N-1];
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.D         = d_reg;
  assign bus.carry_out = carry_reg;
  assign bus.zero      = zero_reg;
  assign bus.negative  = negative_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
endmodule

// File: tb/tb_alu_seq_n.sv
// Directed bench for alu_seq_n (N=32): single-cycle ops, iterative shifts,
// busy-time start rejection, back-to-back issue and reset mid-shift.
module tb_alu_seq_n;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  alu_seq_n_if #(.N(32)) bus ();

  alu_seq_n #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.CNT   = op;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic c, input logic z,
                             input logic n, input logic v);
    check({tag, ".carry"}, {31'd0, bus.carry_out}, {31'd0, c});
    check({tag, ".zero"},  {31'd0, bus.zero},      {31'd0, z});
    check({tag, ".neg"},   {31'd0, bus.negative},  {31'd0, n});
    check({tag, ".ovf"},   {31'd0, bus.overflow},  {31'd0, v});
  endtask

  // Op that must finish at its accept edge.
  task automatic one_cycle(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_d,
                           input logic c, input logic z, input logic n, input logic v);
    issue(op, a, b);
    check({tag, ".d"},    bus.D, exp_d);
    check({tag, ".done"}, {31'd0, bus.done}, 32'd1);
    check({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
    check_flags(tag, c, z, n, v);
    $display("op %s cnt=%h A=%h B=%h -> D=%h c=%b z=%b n=%b v=%b", tag, op, a, b,
             bus.D, bus.carry_out, bus.zero, bus.negative, bus.overflow);
  endtask

  // Iterative op: busy must last exactly k cycles; optionally pulse start while busy.
  task automatic shift_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int k, input logic [31:0] exp_d,
                          input logic c, input logic n, input bit inject);
    int busy_cnt;
    bit got_done;
    logic [31:0] d_before;
    d_before = bus.D;
    issue(op, a, b);
    check({tag, ".busy0"}, {31'd0, bus.busy}, 32'd1);
    check({tag, ".done0"}, {31'd0, bus.done}, 32'd0);
    busy_cnt = 1;
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      busy_cnt += bus.busy ? 1 : 0;
      if (i == 0) check({tag, ".dhold"}, bus.D, d_before);
      if (inject && i == 0) begin
        bus.start = 1'b1;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.CNT   = 4'h0;
      end else if (inject && i == 1) begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({tag, ".finished"}, {31'd0, got_done}, 32'd1);
    check({tag, ".busycyc"}, busy_cnt, k);
    check({tag, ".busyend"}, {31'd0, bus.busy}, 32'd0);
    check({tag, ".d"}, bus.D, exp_d);
    check_flags(tag, c, (exp_d == 32'd0), n, 1'b0);
    $display("op %s cnt=%h A=%h B=%h -> D=%h c=%b busy_cycles=%0d", tag, op, a, b,
             bus.D, bus.carry_out, busy_cnt);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.start = 1'b1;  // must be ignored while in reset
    bus.A     = 32'h1234_5678;
    bus.B     = 32'h1;
    bus.CNT   = 4'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.d",    bus.D, 32'd0);
    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.done", {31'd0, bus.done}, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    $display("reset released");
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;

    one_cycle("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("add_wrap.done_clear", {31'd0, bus.done}, 32'd0);
    check("add_wrap.d_hold", bus.D, 32'h0);

    one_cycle("sub_neg",  4'h1, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    one_cycle("sub_ovf",  4'h1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    one_cycle("add_ovf",  4'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    one_cycle("lt",       4'h3, 32'h3, 32'h7, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    one_cycle("ne_false", 4'h4, 32'h3, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    one_cycle("eq",       4'h5, 32'h3, 32'h3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    one_cycle("and",      4'h6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b1, 1'b0);
    one_cycle("or",       4'h7, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0, 1'b0);
    one_cycle("xor",      4'h8, 32'hA5A5_A5A5, 32'h0000_FFFF, 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b1, 1'b0);
    one_cycle("ror_k0",   4'hA, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0);
    one_cycle("op_e",     4'hE, 32'h1, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

    shift_op("rol4",   4'h9, 32'h8000_0001, 32'h4, 4, 32'h0000_0018, 1'b0, 1'b0, 1'b1);
    shift_op("ror1",   4'hA, 32'h0000_0001, 32'h1, 1, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    shift_op("srl2",   4'hC, 32'h0000_0006, 32'h2, 2, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    shift_op("sra31",  4'hD, 32'h8000_0000, 32'd31, 31, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    shift_op("sll_m5", 4'hB, 32'h0000_0001, 32'h25, 5, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
    // issued in the done cycle of the shift above: no bubble
    one_cycle("ge_b2b", 4'h2, 32'h3, 32'h3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    one_cycle("op_f",   4'hF, 32'h3, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    one_cycle("xor_pre", 4'h8, 32'hFFFF_0000, 32'h0000_000F, 32'hFFFF_000F, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a 20-step srl
    issue(4'hC, 32'hFFFF_FFFF, 32'd20);
    repeat (6) @(posedge clk);
    #1;
    check("abort.busy_before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort.d", bus.D, 32'd0);
    check("abort.busy", {31'd0, bus.busy}, 32'd0);
    check("abort.done", {31'd0, bus.done}, 32'd0);
    check_flags("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort.no_done", {31'd0, bus.done}, 32'd0);
    end
    $display("reset mid-shift applied");
    @(negedge clk);
    rst = 1'b0;
    one_cycle("add_after", 4'h0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/alu_seq_n.md
# alu_seq_n

Parametrised, registered N-bit ALU with a start/busy/done handshake and status flags. Arithmetic, compare and logic ops complete in one cycle. Rotates and shifts run iteratively, one bit position per clock, so no barrel shifter is needed. It is the sequential successor to the 32-bit combinational ALU and sits between the operand registers and the writeback path of the datapath.

## Interface
- N, 32, operand/result width; must be a power of two, ≥4. Localparam S = clog2(N) is the shift-amount width.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted on a clk edge when busy=0
- A  in  N  operand A
- B  in  N  operand B; shifts/rotates use B[S-1:0] only
- CNT  in  4  opcode, sampled with start
- D  out  N  registered result; held until the next completion
- carry_out  out  1  carry / no-borrow / last bit shifted out
- zero  out  1  D == 0
- negative  out  1  D[N-1]
- overflow  out  1  signed overflow (add/sub only)
- busy  out  1  iterative op in progress
- done  out  1  one-cycle completion pulse

## Operation
- Opcodes (CNT):
  - 0: A+B
  - 1: A−B as A+~B+1
  - 2: A≥B unsigned
  - 3: A<B unsigned
  - 4: A≠B
  - 5: A==B
  - 6: AND
  - 7: OR
  - 8: XOR
  - 9: rol
  - A: ror
  - B: sll
  - C: srl
  - D: sra (new)
  - E–F: D=0
- Compares (2–5): D = all ones if true, all zeros if false.
- Arithmetic: mod 2^N.
- carry_out by opcode:
  - add: carry out of bit N-1.
  - sub: carry of A+~B+1, i.e. 1 when A≥B unsigned.
  - rol/ror: the bit wrapped on the final step.
  - sll/srl/sra: the bit shifted out on the final step.
  - k=0 and all other ops: 0.
- overflow:
  - add: A[N-1]==B[N-1] and D[N-1]≠A[N-1].
  - sub: A[N-1]≠B[N-1] and D[N-1]≠A[N-1].
  - otherwise 0.
- zero and negative are derived from the new D, for every op.
- FSM:
  - IDLE → SHIFT on an accepted shift/rotate with k = B[S-1:0] ≥ 1.
  - All other accepted ops stay in IDLE.
  - SHIFT: each edge shifts an internal accumulator by one position and decrements the remaining count. When the count reaches 0, D/flags are written, done is pulsed, and the FSM returns to IDLE.
- Operands and opcode are captured at accept. Input changes while busy have no effect.
- sra replicates the captured A[N-1]. srl/sll fill with 0.

## Timing
- Reset (async, immediate): D=0, carry_out=0, zero=0, negative=0, overflow=0, busy=0, done=0, FSM=IDLE.
- Accept at edge t (start=1, busy=0):
  - Non-shift op, or shift with k=0: D, flags and done=1 are updated at edge t. Latency is 1 cycle and busy never rises.
  - Shift with k≥1: busy=1 from edge t. D, flags and done=1 are updated at edge t+k, and busy=0 at the same edge. busy is high for exactly k cycles.
- done is high for exactly one cycle. It is cleared at the next edge unless another op completes at that edge.
- start while busy=1 is ignored, with no queuing.
- start in the done cycle is accepted, so ops run back-to-back with no bubble.
- D/flags change only at completion edges. They hold their values between completions.
- Reset mid-SHIFT aborts the op: no done, and outputs take their reset values.
- A start asserted during reset is ignored. The first accept is at the first edge after rst deasserts.

## Test plan
- Add, N=32: A=FFFFFFFF, B=1, CNT=0 → at edge t: D=0, carry_out=1, zero=1, overflow=0, done=1; next cycle done=0.
- Sub: A=5, B=7, CNT=1 → D=FFFFFFFE, carry_out=0, negative=1. Also A=80000000, B=1, CNT=1 → D=7FFFFFFF, overflow=1.
- Rotate: A=80000001, B=4, CNT=9 → busy=1 for 4 cycles, then D=00000018, carry_out=0, done pulse at t+4. Pulse start with A=0 during busy → ignored; result is unchanged.
- Arithmetic shift: A=80000000, B=31, CNT=D → busy 31 cycles, D=FFFFFFFF, negative=1, carry_out=0.
- Amount masking/compare: A=1, B=25 (hex), CNT=B → k=5, D=00000020 at t+5. Then A=3, B=3, CNT=2 → D=FFFFFFFF in 1 cycle. Then CNT=F → D=0, zero=1.
- Reset mid-shift: start srl with k=20, assert rst at cycle 7 → all outputs 0 immediately, no done. After release, an add of 2+3 → D=5 at its accept edge.
